// File: rtl/text_pixel_renderer.sv
// text_pixel_renderer: 3-stage glyph-to-RGB565 pixel pipeline with cursor overlay.
// Cursor blink counter is built only when TEXT_CURSOR_BLINK_EN is defined.
module text_pixel_renderer #(
    parameter int cursorBlinkFrames = 30
) (
    input  logic        pixelClock,
    input  logic        reset,
    input  logic [7:0]  screenCharCode,
    input  logic [2:0]  asciiLineIndex,
    input  logic [2:0]  asciiBitSelector,
    input  logic [15:0] foreGroundColor,
    input  logic [15:0] backGroundColor,
    input  logic        cursorVisible,
    input  logic        activeIn,
    input  logic        hsyncIn,
    input  logic        vsyncIn,
    output logic [9:0]  fontAddress,
    input  logic [7:0]  fontData,
    output logic [15:0] pixelColor,
    output logic        activeOut,
    output logic        hsyncOut,
    output logic        vsyncOut
);
    typedef struct packed {
        logic [2:0]  sel;
        logic        inv;
        logic        cur;
        logic [15:0] fg;
        logic [15:0] bg;
        logic        act;
        logic        hs;
        logic        vs;
    } side_t;

    logic [9:0]  font_address_q, font_address_d;
    side_t       s1_q, s1_d, s2_q, s2_d;
    logic [15:0] pixel_color_q, pixel_color_d;
    logic [2:0]  sync_q, sync_d;
    logic        glyph_bit;
    logic        blink_phase;

    always_comb begin
        font_address_d = {screenCharCode[6:0], asciiLineIndex};
        s1_d.sel       = asciiBitSelector;
        s1_d.inv       = screenCharCode[7];
        s1_d.cur       = cursorVisible;
        s1_d.fg        = foreGroundColor;
        s1_d.bg        = backGroundColor;
        s1_d.act       = activeIn;
        s1_d.hs        = hsyncIn;
        s1_d.vs        = vsyncIn;
        s2_d           = s1_q;
        glyph_bit      = fontData[s2_q.sel] ^ s2_q.inv;
        pixel_color_d  = !s2_q.act ? 16'h0000 :
                         (s2_q.cur & blink_phase) ? s2_q.fg :
                         glyph_bit ? s2_q.fg : s2_q.bg;
        sync_d         = {s2_q.act, s2_q.hs, s2_q.vs};
    end

    always_ff @(posedge pixelClock or posedge reset) begin
        if (reset) begin
            font_address_q <= '0;
            s1_q           <= '0;
            s2_q           <= '0;
            pixel_color_q  <= '0;
            sync_q         <= '0;
        end else begin
            font_address_q <= font_address_d;
            s1_q           <= s1_d;
            s2_q           <= s2_d;
            pixel_color_q  <= pixel_color_d;
            sync_q         <= sync_d;
        end
    end

`ifdef TEXT_CURSOR_BLINK_EN
    localparam logic [7:0] BLINK_LAST = 8'(cursorBlinkFrames - 1);
    logic [7:0] frame_counter_q, frame_counter_d;
    logic       blink_phase_q, blink_phase_d;
    logic       rise;
    logic       wrap;

    // The pixel in stage 3 sees the phase before any toggle on this same edge.
    always_comb begin
        rise            = s1_q.vs & ~s2_q.vs;
        wrap            = rise && (frame_counter_q == BLINK_LAST);
        frame_counter_d = wrap ? 8'd0 : rise ? frame_counter_q + 8'd1 : frame_counter_q;
        blink_phase_d   = blink_phase_q ^ wrap;
    end

    always_ff @(posedge pixelClock or posedge reset) begin
        if (reset) begin
            frame_counter_q <= '0;
            blink_phase_q   <= 1'b1;
        end else begin
            frame_counter_q <= frame_counter_d;
            blink_phase_q   <= blink_phase_d;
        end
    end

    assign blink_phase = blink_phase_q;
`else
    logic [7:0] unused_blink_frames;
    assign unused_blink_frames = 8'(cursorBlinkFrames);
    assign blink_phase = 1'b1;
`endif

    assign fontAddress = font_address_q;
    assign pixelColor  = pixel_color_q;
    assign activeOut   = sync_q[2];
    assign hsyncOut    = sync_q[1];
    assign vsyncOut    = sync_q[0];
endmodule

// File: tb/tb_text_pixel_renderer.sv
// tb_text_pixel_renderer: directed + randomized check of text_pixel_renderer against a frame-level model.
module tb_text_pixel_renderer;
    localparam int N = 2;

    logic        pixelClock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  screenCharCode = '0;
    logic [2:0]  asciiLineIndex = '0;
    logic [2:0]  asciiBitSelector = '0;
    logic [15:0] foreGroundColor = '0;
    logic [15:0] backGroundColor = '0;
    logic        cursorVisible = 1'b0;
    logic        activeIn = 1'b0;
    logic        hsyncIn = 1'b0;
    logic        vsyncIn = 1'b0;
    logic [9:0]  fontAddress;
    logic [7:0]  fontData = '0;
    logic [15:0] pixelColor;
    logic        activeOut;
    logic        hsyncOut;
    logic        vsyncOut;

    text_pixel_renderer #(.cursorBlinkFrames(N)) dut (
        .pixelClock(pixelClock), .reset(reset),
        .screenCharCode(screenCharCode), .asciiLineIndex(asciiLineIndex),
        .asciiBitSelector(asciiBitSelector), .foreGroundColor(foreGroundColor),
        .backGroundColor(backGroundColor), .cursorVisible(cursorVisible),
        .activeIn(activeIn), .hsyncIn(hsyncIn), .vsyncIn(vsyncIn),
        .fontAddress(fontAddress), .fontData(fontData), .pixelColor(pixelColor),
        .activeOut(activeOut), .hsyncOut(hsyncOut), .vsyncOut(vsyncOut)
    );

    always #5 pixelClock = ~pixelClock;

    logic [7:0] rom [1024];
    always @(posedge pixelClock) fontData <= rom[fontAddress];

    int errors = 0;
    int checks = 0;
    logic [18:0] exp_q [$];
    int rises;
    logic vs_prev;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, want);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_q.push_back(19'd0);
        exp_q.push_back(19'd0);
        rises = 0;
        vs_prev = 1'b0;
    endtask

    function automatic logic phase_now();
`ifdef TEXT_CURSOR_BLINK_EN
        return ((rises / N) % 2) == 0;
`else
        return 1'b1;
`endif
    endfunction

    task automatic setin(input logic [7:0] ch, input logic [2:0] ln, input logic [2:0] sel,
                         input logic [15:0] fg, input logic [15:0] bg,
                         input logic cur, input logic act, input logic hs, input logic vs);
        screenCharCode = ch; asciiLineIndex = ln; asciiBitSelector = sel;
        foreGroundColor = fg; backGroundColor = bg;
        cursorVisible = cur; activeIn = act; hsyncIn = hs; vsyncIn = vs;
    endtask

    task automatic step();
        logic [7:0]  row;
        logic        b;
        logic [15:0] pix;
        logic [9:0]  addr;
        logic [18:0] e;
        if (vsyncIn && !vs_prev) rises++;
        vs_prev = vsyncIn;
        addr = {screenCharCode[6:0], asciiLineIndex};
        row = rom[addr];
        b = row[asciiBitSelector] ^ screenCharCode[7];
        pix = !activeIn ? 16'h0000 : (cursorVisible && phase_now()) ? foreGroundColor :
              b ? foreGroundColor : backGroundColor;
        exp_q.push_back({pix, activeIn, hsyncIn, vsyncIn});
        @(posedge pixelClock);
        @(negedge pixelClock);
        e = exp_q.pop_front();
        chk("pixel", pixelColor, e[18:3]);
        chk("active", {15'd0, activeOut}, {15'd0, e[2]});
        chk("hsync", {15'd0, hsyncOut}, {15'd0, e[1]});
        chk("vsync", {15'd0, vsyncOut}, {15'd0, e[0]});
        chk("fontaddr", {6'd0, fontAddress}, {6'd0, addr});
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 8'($urandom);
        rom[10'h20B] = 8'h80;
        rom[10'h000] = 8'h00;
        rom[10'h3FF] = 8'hFF;

        #1 reset = 1'b1;
        @(negedge pixelClock);
        chk("rst_pixel", pixelColor, 16'h0000);
        chk("rst_fontaddr", {6'd0, fontAddress}, 16'h0000);
        chk("rst_syncs", {13'd0, activeOut, hsyncOut, vsyncOut}, 16'h0000);
        model_reset();
        reset = 1'b0;

        setin(8'h41, 3'd3, 3'd7, 16'hFFFF, 16'h001F, 1'b0, 1'b1, 1'b0, 1'b0); step();
        chk("tp_fontaddr", {6'd0, fontAddress}, 16'h020B);
        setin(8'hC1, 3'd3, 3'd7, 16'hFFFF, 16'h001F, 1'b0, 1'b1, 1'b0, 1'b0); step();
        setin(8'hC1, 3'd3, 3'd6, 16'hFFFF, 16'h001F, 1'b0, 1'b1, 1'b0, 1'b0); step();
        chk("tp_glyph", pixelColor, 16'hFFFF);
        setin(8'h7F, 3'd7, 3'd2, 16'hFFFF, 16'h001F, 1'b0, 1'b0, 1'b1, 1'b0); step();
        chk("tp_inverse7", pixelColor, 16'h001F);
        setin(8'h00, 3'd0, 3'd0, 16'h1234, 16'h5678, 1'b0, 1'b1, 1'b0, 1'b0); step();
        chk("tp_inverse6", pixelColor, 16'hFFFF);
        step();
        chk("tp_blank", pixelColor, 16'h0000);

        setin(8'h00, 3'd0, 3'd0, 16'hF800, 16'h07E0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step();
        chk("blink_start", pixelColor, 16'hF800);
        for (int p = 1; p <= 4; p++) begin
            vsyncIn = 1'b1;
            for (int i = 0; i < 3; i++) step();
            vsyncIn = 1'b0;
            for (int i = 0; i < 5; i++) step();
`ifdef TEXT_CURSOR_BLINK_EN
            if (p == 2) chk("blink_rise2", pixelColor, 16'h07E0);
`else
            if (p == 2) chk("blink_rise2", pixelColor, 16'hF800);
`endif
            if (p == 4) chk("blink_rise4", pixelColor, 16'hF800);
        end

        for (int l = 0; l < 2; l++) begin
            for (int i = 0; i < 1650; i++) begin
                if (i % 64 == 0) begin
                    foreGroundColor = 16'($urandom);
                    backGroundColor = 16'($urandom);
                end
                screenCharCode = 8'($urandom);
                asciiLineIndex = 3'($urandom);
                asciiBitSelector = 3'($urandom);
                cursorVisible = ($urandom_range(0, 3) == 0);
                activeIn = (i < 1280);
                hsyncIn = (i >= 1390 && i < 1430);
                vsyncIn = (i >= 1500 && i < 1506) || (i >= 1600 && i < 1604);
                step();
            end
        end

        setin(8'h41, 3'd3, 3'd7, 16'hABCD, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step();
        chk("pre_reset_fg", pixelColor, 16'hABCD);
        #2 reset = 1'b1;
        #1;
        chk("midrst_pixel", pixelColor, 16'h0000);
        chk("midrst_active", {15'd0, activeOut}, 16'h0000);
        model_reset();
        @(negedge pixelClock);
        reset = 1'b0;
        setin(8'h00, 3'd0, 3'd0, 16'h0F0F, 16'h3333, 1'b1, 1'b1, 1'b1, 1'b0); step();
        setin(8'h41, 3'd3, 3'd7, 16'h00FF, 16'h3333, 1'b0, 1'b1, 1'b0, 1'b0); step();
        chk("post_rst_gap", pixelColor, 16'h0000);
        step();
        chk("post_rst_cursor", pixelColor, 16'h0F0F);
        step();
        chk("post_rst_glyph", pixelColor, 16'h00FF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
